alu_sequencer: RTL and testbench

Command front-end that sits directly upstream of the 8-bit bitslice ALU array. It accepts operation commands over a valid/ready handshake and registers the operands. It drives the array's operand, opcode and carry/shift-in inputs, captures the array result and returns it over a second valid/ready handshake. It also implements a multi-cycle unsigned 8x8 multiply by iterating the array's ADD operation.

---
 rtl/alu_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Command front-end for the W-slice bitslice ALU array: passes array ops through,
// runs an unsigned shift-add multiply, and returns results over valid/ready.
module alu_sequencer #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [3:0]     cmd_op,
  input  logic [W-1:0]   cmd_x,
  input  logic [W-1:0]   cmd_y,
  input  logic           cmd_cin,
  input  logic           cmd_shin,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_data,
  output logic           rsp_cout,
  output logic           rsp_err,
  output logic [3:0]     alu_op,
  output logic [W-1:0]   alu_x,
  output logic [W-1:0]   alu_y,
  output logic           alu_cin,
  output logic           alu_cin2c,
  output logic           alu_left_i,
  output logic           alu_right_i,
  input  logic [W-1:0]   alu_z,
  input  logic           alu_cout
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_LAST_PT = 4'b1000;
  localparam logic [3:0] OP_MUL     = 4'b1111;

  state_t         state;
  logic [3:0]     op_q;
  logic [W-1:0]   x_q;
  logic [W-1:0]   y_q;
  logic           cin_q;
  logic           shin_q;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic [3:0]     cnt;
  logic [2*W-1:0] mul_next;

  // Sum lands in the top W+1 bits while the multiplier shifts out of lo.
  assign mul_next  = {alu_cout, alu_z, lo[W-1:1]};

  assign cmd_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);

  // Array drive is decoded from registered state; the multiplicand lives in x_q.
  always_comb begin
    alu_op      = '0;
    alu_x       = '0;
    alu_y       = '0;
    alu_cin     = 1'b0;
    alu_cin2c   = 1'b0;
    alu_left_i  = 1'b0;
    alu_right_i = 1'b0;
    if (!rst) begin
      unique case (state)
        EXEC: begin
          alu_op      = op_q;
          alu_x       = x_q;
          alu_y       = y_q;
          alu_cin2c   = (op_q == OP_SUB);
          alu_cin     = (op_q == OP_SUB) ? 1'b1 : cin_q;
          alu_left_i  = shin_q;
          alu_right_i = shin_q;
        end
        MUL: begin
          alu_x = hi;
          alu_y = lo[0] ? x_q : '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cin_q    <= 1'b0;
      shin_q   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_cout <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            x_q    <= cmd_x;
            y_q    <= cmd_y;
            cin_q  <= cmd_cin;
            shin_q <= cmd_shin;
            if (cmd_op <= OP_LAST_PT) begin
              rsp_err <= 1'b0;
              state   <= EXEC;
            end else if (cmd_op == OP_MUL) begin
              rsp_err <= 1'b0;
              hi      <= '0;
              lo      <= cmd_y;
              cnt     <= '0;
              state   <= MUL;
            end else begin
              rsp_data <= '0;
              rsp_cout <= 1'b0;
              rsp_err  <= 1'b1;
              state    <= RESP;
            end
          end
        end
        EXEC: begin
          rsp_data <= {{W{1'b0}}, alu_z};
          rsp_cout <= alu_cout;
          state    <= RESP;
        end
        MUL: begin
          {hi, lo} <= mul_next;
          cnt      <= cnt + 4'd1;
          if (cnt == 4'(W - 1)) begin
            rsp_data <= mul_next;
            rsp_cout <= 1'b0;
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural model of the ALU array.
module tb_alu_sequencer;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [3:0]     cmd_op;
  logic [W-1:0]   cmd_x;
  logic [W-1:0]   cmd_y;
  logic           cmd_cin;
  logic           cmd_shin;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_data;
  logic           rsp_cout;
  logic           rsp_err;
  logic [3:0]     alu_op;
  logic [W-1:0]   alu_x;
  logic [W-1:0]   alu_y;
  logic           alu_cin;
  logic           alu_cin2c;
  logic           alu_left_i;
  logic           alu_right_i;
  logic [W-1:0]   alu_z;
  logic           alu_cout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] obs_op;
  logic       obs_cin;
  logic       obs_cin2c;
  int         lat;

  alu_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_cin(cmd_cin), .cmd_shin(cmd_shin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_cin(alu_cin),
    .alu_cin2c(alu_cin2c), .alu_left_i(alu_left_i), .alu_right_i(alu_right_i),
    .alu_z(alu_z), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Array model: 0000 ADD, 0001 SUB (same adder, y complemented), 0010 AND, 0011 SHR, 0100 SHL.
  always_comb begin
    logic [W:0] sum;
    sum      = {1'b0, alu_x} + {1'b0, (alu_cin2c ? ~alu_y : alu_y)} + {{W{1'b0}}, alu_cin};
    alu_z    = alu_x ^ alu_y;
    alu_cout = 1'b0;
    case (alu_op)
      4'b0000, 4'b0001: {alu_cout, alu_z} = sum;
      4'b0010: alu_z = alu_x & alu_y;
      4'b0011: begin alu_z = {alu_left_i, alu_x[W-1:1]}; alu_cout = alu_x[0]; end
      4'b0100: begin alu_z = {alu_x[W-2:0], alu_right_i}; alu_cout = alu_x[W-1]; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a command, capture the array drive in the cycle after acceptance,
  // then count edges until rsp_valid (0 = already valid right after the accept edge).
  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic cin, input logic shin);
    @(negedge clk);
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_cin = cin; cmd_shin = shin;
    cmd_valid = 1'b1;
    check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    obs_op = alu_op; obs_cin = alu_cin; obs_cin2c = alu_cin2c;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
    check("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic bad;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
    cmd_cin = 1'b0; cmd_shin = 1'b0; rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_flags", {30'd0, rsp_cout, rsp_err}, 32'd0);
    check("rst_alu_out", {alu_op, alu_x, alu_y, alu_cin, alu_cin2c, alu_left_i, alu_right_i}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    check("cmd_ready_first_cycle", 32'(cmd_ready), 32'd1);

    // ADD 0x3C + 0xC5 = 0x101
    issue(4'b0000, 8'h3C, 8'hC5, 1'b0, 1'b0);
    check("add_cin2c", 32'(obs_cin2c), 32'd0);
    check("add_lat", lat, 1);
    check("add_data", 32'(rsp_data), 32'h0001);
    check("add_cout", 32'(rsp_cout), 32'd1);
    check("add_err", 32'(rsp_err), 32'd0);
    release_rsp();

    // SUB 0x10 - 0x01 = 0x0F, no borrow
    issue(4'b0001, 8'h10, 8'h01, 1'b0, 1'b0);
    check("sub_op", 32'(obs_op), 32'd1);
    check("sub_cin2c", 32'(obs_cin2c), 32'd1);
    check("sub_cin", 32'(obs_cin), 32'd1);
    check("sub_data", 32'(rsp_data), 32'h000F);
    check("sub_cout", 32'(rsp_cout), 32'd1);
    release_rsp();

    issue(4'b1111, 8'hFF, 8'hFF, 1'b0, 1'b0);
    check("mul_ff_op", 32'(obs_op), 32'd0);
    check("mul_ff_lat", lat, 8);
    check("mul_ff_data", 32'(rsp_data), 32'hFE01);
    check("mul_ff_cout", 32'(rsp_cout), 32'd0);
    release_rsp();

    issue(4'b1111, 8'h00, 8'hA5, 1'b0, 1'b0);
    check("mul_zero_data", 32'(rsp_data), 32'h0000);
    release_rsp();

    issue(4'b1111, 8'h0D, 8'h0B, 1'b0, 1'b0);
    check("mul_0d0b_lat", lat, 8);
    check("mul_0d0b_data", 32'(rsp_data), 32'h008F);
    release_rsp();

    // SHL 0x81 with fill 1 -> 0x03, carry-out 1; hold rsp_ready low
    issue(4'b0100, 8'h81, 8'h00, 1'b0, 1'b1);
    check("shl_lat", lat, 1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cmd_op = 4'b0000; cmd_x = 8'h01; cmd_y = 8'h01; cmd_valid = 1'b1;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (!rsp_valid || rsp_data !== 16'h0003 || rsp_cout !== 1'b1 || cmd_ready !== 1'b0)
        bad = 1'b1;
    end
    check("stall_stable", 32'(bad), 32'd0);
    check("shl_data", 32'(rsp_data), 32'h0003);
    release_rsp();
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid) bad = 1'b1;
    end
    check("stall_pulse_ignored", 32'(bad), 32'd0);

    issue(4'b1010, 8'h55, 8'h66, 1'b1, 1'b1);
    check("rsv_lat", lat, 0);
    check("rsv_err", 32'(rsp_err), 32'd1);
    check("rsv_data", 32'(rsp_data), 32'd0);
    check("rsv_alu_idle", {alu_op, alu_x, alu_y, alu_cin, alu_cin2c, alu_left_i, alu_right_i}, 32'd0);
    release_rsp();
    issue(4'b0000, 8'h01, 8'h02, 1'b1, 1'b0);
    check("after_rsv_err", 32'(rsp_err), 32'd0);
    check("after_rsv_data", 32'(rsp_data), 32'h0004);
    release_rsp();

    // Abort a multiply in its cnt=4 cycle
    @(negedge clk);
    cmd_op = 4'b1111; cmd_x = 8'hFF; cmd_y = 8'hFF; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_alu_zero", {alu_op, alu_x, alu_y, alu_cin, alu_cin2c, alu_left_i, alu_right_i}, 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0; #1;
    check("abort_cmd_ready_release", 32'(cmd_ready), 32'd1);
    bad = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rsp_valid) bad = 1'b1;
    end
    check("abort_no_rsp", 32'(bad), 32'd0);
    issue(4'b1111, 8'h02, 8'h03, 1'b0, 1'b0);
    check("mul_after_rst", 32'(rsp_data), 32'h0006);
    release_rsp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
